fetch_queue: RTL and testbench

Decode-side receiver for the instruction-fetch output. Accepts up to two fetched packets per cycle from the IF stage over a valid/ready handshake, buffers them in a circular queue, and presents them one at a time, in program order, to decode. A flush from the back end empties the queue. The block sits between IF and decode.

---
 rtl/fetch_queue_pkg.sv | 21 ++
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue_mem.sv | 37 +++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Types and sizes shared by the fetch queue, its storage and the IF/decode
//   side of the bus.
//   - fetched_packet : one fetched packet {pc, data, taken_branch, pkt_valid}
//   - PC_BITS        : width of the packet PC
//   - PACKET_SIZE    : flattened width of one fetched_packet
package fetch_queue_pkg;

   localparam int PC_BITS   = 32;
   localparam int DATA_BITS = 32;

   typedef struct packed {
      logic [PC_BITS-1:0]   pc;
      logic [DATA_BITS-1:0] data;
      logic                 taken_branch;
      logic                 pkt_valid;
   } fetched_packet;

   localparam int PACKET_SIZE = $bits(fetched_packet);

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the IF-side push handshake, the decode-side pop handshake, the
//   back-end flush and the occupancy report.
//   master : IF/decode/back-end side (drives data_in, valid_in, must_flush,
//            ready_in; observes ready_o, data_o, valid_o, occupancy)
//   slave  : the fetch queue itself
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8
);

   logic [2*PACKET_SIZE-1:0]  data_in;     // {packet_b, packet_a}, packet_a older
   logic                      valid_in;
   logic                      ready_o;
   logic                      must_flush;
   logic [PACKET_SIZE-1:0]    data_o;
   logic                      valid_o;
   logic                      ready_in;
   logic [$clog2(DEPTH):0]    occupancy;

   modport master (
      output data_in, valid_in, must_flush, ready_in,
      input  ready_o, data_o, valid_o, occupancy
   );

   modport slave (
      input  data_in, valid_in, must_flush, ready_in,
      output ready_o, data_o, valid_o, occupancy
   );

endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem
//   DEPTH x WIDTH packet storage. Two write ports hitting consecutive
//   addresses (waddr_i and waddr_i+1, wrapping modulo DEPTH) and one
//   combinational read port. Contents are not reset; validity is tracked by
//   the pointers and count in the parent.
//   Ports: clk, we0_i/wdata0_i (at waddr_i), we1_i/wdata1_i (at waddr_i+1),
//          raddr_i -> rdata_o.
module fetch_queue_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we0_i,
   input  logic                     we1_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata0_i,
   input  logic [WIDTH-1:0]         wdata1_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] waddr1;

   // Power-of-two depth: natural overflow gives the wrap to entry 0.
   assign waddr1 = waddr_i + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (we0_i) mem_q[waddr_i] <= wdata0_i;
      if (we1_i) mem_q[waddr1]  <= wdata1_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Decode-side receiver for instruction fetch. Accepts up to two packets per
//   cycle from IF, buffers them in a circular queue and presents them one at
//   a time, oldest first, to decode. must_flush empties the queue.
//   Ports: clk, rst (synchronous, active-high), bus (fetch_queue_if.slave).
//   Build option: FETCH_QUEUE_BYPASS_EN lets the first valid incoming packet
//   reach data_o combinationally while the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   fetch_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   fetched_packet          pkt_a, pkt_b, wr_pkt0;
   logic [PACKET_SIZE-1:0] rd_data;
   logic                   ready_int, valid_int;
   logic                   push, pop, a_v, b_v;
   logic                   bypass, byp_pop, store_pop;
   logic                   we0, we1;
   logic [1:0]             n_write;

   assign pkt_a = fetched_packet'(bus.data_in[PACKET_SIZE-1:0]);
   assign pkt_b = fetched_packet'(bus.data_in[2*PACKET_SIZE-1:PACKET_SIZE]);

   // Needs room for a full pair; independent of valid_in.
   assign ready_int = !rst && !bus.must_flush && (occ_q <= OCC_W'(DEPTH - 2));
   assign push      = bus.valid_in && ready_int;
   assign a_v       = push && pkt_a.pkt_valid;
   assign b_v       = push && pkt_b.pkt_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
   // push already implies no flush and no reset.
   assign bypass = (occ_q == '0) && (a_v || b_v);
`else
   assign bypass = 1'b0;
`endif

   assign valid_int = !rst && !bus.must_flush && ((occ_q != '0) || bypass);
   assign pop       = valid_int && bus.ready_in;
   assign byp_pop   = pop && bypass;
   assign store_pop = pop && !bypass;

   // Pack accepted packets onto consecutive slots. A packet consumed through
   // the bypass is never written.
   always_comb begin
      we0     = 1'b0;
      we1     = 1'b0;
      wr_pkt0 = pkt_a;
      n_write = 2'd0;
      if (byp_pop) begin
         if (a_v && b_v) begin
            we0     = 1'b1;
            wr_pkt0 = pkt_b;
            n_write = 2'd1;
         end
      end else if (a_v && b_v) begin
         we0     = 1'b1;
         we1     = 1'b1;
         n_write = 2'd2;
      end else if (a_v) begin
         we0     = 1'b1;
         n_write = 2'd1;
      end else if (b_v) begin
         we0     = 1'b1;
         wr_pkt0 = pkt_b;
         n_write = 2'd1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(n_write);
      rd_ptr_d = rd_ptr_q + PTR_W'(store_pop);
      occ_d    = occ_q + OCC_W'(n_write) - OCC_W'(store_pop);
      if (bus.must_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (PACKET_SIZE)
   ) u_mem (
      .clk      (clk),
      .we0_i    (we0),
      .we1_i    (we1),
      .waddr_i  (wr_ptr_q),
      .wdata0_i (wr_pkt0),
      .wdata1_i (pkt_b),
      .raddr_i  (rd_ptr_q),
      .rdata_o  (rd_data)
   );

   always_comb begin
      bus.data_o = '0;
      if (valid_int) begin
         if (bypass) bus.data_o = a_v ? pkt_a : pkt_b;
         else        bus.data_o = rd_data;
      end
   end

   assign bus.ready_o   = ready_int;
   assign bus.valid_o   = valid_int;
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed scenarios followed by randomized traffic. Stimulus appends every
//   accepted packet to a reference queue; a negedge monitor compares
//   ready_o/valid_o/occupancy/data_o against that queue and retires entries
//   on each pop. Honors FETCH_QUEUE_BYPASS_EN when defined.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   fetched_packet exp_q[$];   // packets expected inside the queue, oldest first
   fetched_packet pend[$];    // packets accepted this cycle, not yet stored
   bit            cur_rst   = 1'b1;
   bit            cur_flush = 1'b0;
   bit            check_en  = 1'b0;
   int            tests = 0;
   int            fails = 0;
   logic [31:0]   pc_next = 32'h1000;

   function automatic void chk(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic fetched_packet mk(input logic [31:0] pc, input bit v);
      fetched_packet p;
      p.pc           = pc;
      p.data         = $urandom;
      p.taken_branch = 1'($urandom_range(0, 1));
      p.pkt_valid    = v;
      return p;
   endfunction

   // One clock cycle: retire the previous cycle's accepted packets into the
   // model, then drive new inputs and decide (from the model) what is accepted.
   task automatic cyc(input bit r, input bit v, input fetched_packet a,
                      input fetched_packet b, input bit fl, input bit ri);
      @(posedge clk);
      if (cur_rst || cur_flush) exp_q.delete();
      else foreach (pend[i]) exp_q.push_back(pend[i]);
      pend.delete();
      #1;
      rst            = r;
      bus.valid_in   = v;
      bus.data_in    = {b, a};
      bus.must_flush = fl;
      bus.ready_in   = ri;
      cur_rst        = r;
      cur_flush      = fl;
      if (!r && !fl && v && (DEPTH - exp_q.size() >= 2)) begin
         if (a.pkt_valid) pend.push_back(a);
         if (b.pkt_valid) pend.push_back(b);
      end
   endtask

   task automatic idle(input bit ri);
      cyc(1'b0, 1'b0, mk(32'h0, 1'b0), mk(32'h0, 1'b0), 1'b0, ri);
   endtask

   task automatic push2(input logic [31:0] pc, input bit ri);
      cyc(1'b0, 1'b1, mk(pc, 1'b1), mk(pc + 32'h4, 1'b1), 1'b0, ri);
   endtask

   always @(negedge clk) begin
      bit            exp_ready, exp_valid;
      fetched_packet exp_pkt;
      if (check_en) begin
         exp_ready = !cur_rst && !cur_flush && (DEPTH - exp_q.size() >= 2);
         exp_valid = !cur_rst && !cur_flush &&
                     ((exp_q.size() > 0) || (BYP && pend.size() > 0));
         chk("ready_o", 128'(bus.ready_o), 128'(exp_ready));
         chk("valid_o", 128'(bus.valid_o), 128'(exp_valid));
         chk("occupancy", 128'(bus.occupancy), 128'(exp_q.size()));
         if (cur_rst) chk("data_o_reset", 128'(bus.data_o), 128'(0));
         if (exp_valid) begin
            exp_pkt = (exp_q.size() > 0) ? exp_q[0] : pend[0];
            chk("data_o", 128'(bus.data_o), 128'(exp_pkt));
            if (bus.ready_in) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               else                  void'(pend.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_in   = 1'b0;
      bus.data_in    = '0;
      bus.must_flush = 1'b0;
      bus.ready_in   = 1'b0;

      // Reset state
      cyc(1'b1, 1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0);
      cyc(1'b1, 1'b1, mk(0, 1), mk(4, 1), 1'b0, 1'b1);
      check_en = 1'b1;
      cyc(1'b1, 1'b1, mk(0, 1), mk(4, 1), 1'b0, 1'b1);

      // Single pair, then two pops
      push2(32'h0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Fill to 8 with decode stalled; further pushes must be refused
      for (int i = 0; i < 4; i++) push2(32'h200 + 32'(8 * i), 1'b0);
      push2(32'h300, 1'b0);
      push2(32'h308, 1'b0);
      for (int i = 0; i < 9; i++) idle(1'b1);

      // Occupancy 7 also blocks
      for (int i = 0; i < 3; i++) push2(32'h400 + 32'(8 * i), 1'b0);
      cyc(1'b0, 1'b1, mk(32'h418, 1), mk(32'h41c, 0), 1'b0, 1'b0);
      push2(32'h500, 1'b0);
      for (int i = 0; i < 8; i++) idle(1'b1);

      // Wrap-around: reach occupancy 5 with wr_ptr 7, then push 0x20/0x24
      cyc(1'b0, 1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
      push2(32'h100, 1'b0);
      push2(32'h108, 1'b0);
      cyc(1'b0, 1'b1, mk(32'h110, 1), mk(32'h114, 0), 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      push2(32'h118, 1'b0);
      push2(32'h20, 1'b0);
      for (int i = 0; i < 8; i++) idle(1'b1);

      // Flush at occupancy 6 with simultaneous push and pop
      for (int i = 0; i < 3; i++) push2(32'h600 + 32'(8 * i), 1'b0);
      cyc(1'b0, 1'b1, mk(32'h700, 1), mk(32'h704, 1), 1'b1, 1'b1);
      idle(1'b0);

      // packet_b invalid counts once
      cyc(1'b0, 1'b1, mk(32'h30, 1), mk(32'h34, 0), 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      // Empty queue push with decode ready (bypass path when enabled)
      push2(32'h40, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         bit r, v, fl, ri;
         fetched_packet a, b;
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 99) < 75);
         fl = ($urandom_range(0, 99) < 3);
         ri = ($urandom_range(0, 99) < 50);
         a  = mk(pc_next, $urandom_range(0, 99) < 85);
         b  = mk(pc_next + 32'h4, $urandom_range(0, 99) < 85);
         pc_next = pc_next + 32'h8;
         cyc(r, v, a, b, fl, ri);
      end

      // Drain
      for (int i = 0; i < 12; i++) idle(1'b1);
      idle(1'b0);
      idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
